fabric_uart_rx: RTL and testbench
=================================

# fabric_uart_rx

Fabric UART receiver that deserialises the `TX` line driven by the MSS subsystem's fabric UART peripheral and buffers received bytes for fabric logic. Sits directly downstream of the MSS top level. It provides 16× oversampled start/data/stop recovery, an 8-deep first-word-fall-through (FWFT) byte FIFO with a valid/ready output, and error strobes for framing and overrun.

## Interface
- `BAUD_DIV`, 27: clock cycles per oversample tick. Bit period is 16×`BAUD_DIV` cycles (27 → 115200 baud at 50 MHz).
- `FIFO_DEPTH`, 8: byte FIFO entries. Must be a power of two, minimum 2.
- `FAB_CCC_GL0`  in  1  fabric clock. One clock domain only.
- `FAB_RESET`  in  1  reset, synchronous, active-high.
- `RX_IN`  in  1  serial line, asynchronous to the clock, idle high.
- `DATA_OUT`  out  8  head-of-FIFO byte, LSB received first.
- `DATA_VALID`  out  1  FIFO non-empty.
- `DATA_READY`  in  1  consumer pops the FIFO when `DATA_VALID`&&`DATA_READY`.
- `FIFO_COUNT`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `FRAME_ERR`  out  1  one-cycle pulse on a bad stop bit.
- `OVERRUN`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `PARITY_ERR`  out  1  one-cycle pulse on a parity mismatch. Tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- `RX_IN` passes through a 2-FF synchroniser before any use.
- Tick counter runs from 0 to `BAUD_DIV`-1 and emits `tick` on wrap. It free-runs only while not in IDLE, and is reloaded to 0 on start detection.
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised falling edge (1→0) moves to START and clears the sample counter.
  - START: at sample 7, if the line is 1 the start was a glitch: return to IDLE, no error. Otherwise at sample 15 go to DATA.
  - DATA: each bit is the majority of samples 7, 8, 9. Bits shift into the MSB of an 8-bit shifter (LSB-first). After 8 bits go to PARITY if enabled, else STOP.
  - STOP: the stop value is the majority of samples 7–9 and is evaluated at sample 9.
    - Stop = 1 and no parity error: push the byte, or pulse `OVERRUN` if the FIFO is full. Go to IDLE.
    - Stop = 0: pulse `FRAME_ERR`, discard the byte, go to BREAK.
- BREAK: wait for the synchronised line to be 1 for one full cycle, then IDLE. A held-low break yields exactly one `FRAME_ERR`.
- FIFO: FWFT, so `DATA_OUT` shows the head combinationally from registered storage. Pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally. Full is the pointers differing only in the MSB.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, the push is accepted because the pop frees a slot, and there is no `OVERRUN`.
  - When empty, the push lands and `DATA_VALID` rises next cycle. No same-cycle bypass.
- Popping while `DATA_VALID`=0 has no effect.

## Timing
- Reset values: `DATA_OUT`=0, `DATA_VALID`=0, `FIFO_COUNT`=0, `FRAME_ERR`=0, `OVERRUN`=0, `PARITY_ERR`=0. The FSM is in IDLE and the synchroniser is preset to 1.
- Reset mid-frame aborts the frame and empties the FIFO. No error pulses are generated.
- Latency is the cycles from the line's stop-bit sample-9 point to the push. `DATA_VALID`=1 one cycle after the push. Total from the start-bit falling edge to `DATA_VALID`≈(9.5×16×`BAUD_DIV`)+4 cycles, including 2 synchroniser cycles. Under `UART_RX_PARITY_EN` add 16×`BAUD_DIV`.
- Error pulses last exactly one cycle and are coincident with the decision cycle.
- Tolerates ±3% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 11 bits, with an even parity bit after bit 7, majority-sampled.
  - On mismatch: pulse `PARITY_ERR`, discard the byte, and still check the stop bit. A bad stop additionally pulses `FRAME_ERR`.
- Undefined: 10-bit frame (8N1), and `PARITY_ERR` is constant 0.

## Structure
- Package `fabric_uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `OVERSAMPLE`=16, `SAMPLE_MID`=8, `DATA_BITS`=8.
- Sub-module `fabric_uart_rx_fifo` (parameter `DEPTH`): storage, pointers, count, full/empty. Its push/pop/data interface is used by the top-level FSM.

## Test plan
Bench uses `BAUD_DIV`=4, so one bit is 64 cycles.
- Send 0xA5 then 0x3C with `DATA_READY`=1 → `DATA_OUT`=0xA5 then 0x3C, each valid for 1 cycle. No error pulses.
- Send 9 bytes 0x00–0x08 with `DATA_READY`=0 → `FIFO_COUNT`=8, one `OVERRUN` on 0x08. Popping yields 0x00–0x07.
- Send 0x55 with stop bit 0, then hold the line low for 200 cycles, then send 0x81 → exactly one `FRAME_ERR`. Only 0x81 is received.
- Drive a 20-cycle low glitch while idle → no push, no error, FSM back in IDLE.
- Assert `FAB_RESET` at data bit 4 of 0xF0 with 3 bytes queued → all outputs 0 next cycle. A following 0x12 is received normally.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → one `PARITY_ERR`, no push. 0x07 with parity 1 → received.

Source files
------------

// File: rtl/fabric_uart_pkg.sv
// Shared types and constants for the fabric UART receiver.
`timescale 1ns/1ps
package fabric_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/fabric_uart_rx_fifo.sv
// FWFT byte FIFO: head visible combinationally from registered storage.
`timescale 1ns/1ps
module fabric_uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still takes the push
  assign do_push = push && (!full || do_pop);
  assign count   = wptr - rptr;
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fabric_uart_rx.sv
// 16x oversampled UART receiver feeding an FWFT byte FIFO.
// Define UART_RX_PARITY_EN for an 8E1 frame with parity checking (default 8N1).
`timescale 1ns/1ps
module fabric_uart_rx
  import fabric_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 8
)(
  input  logic                        FAB_CCC_GL0,
  input  logic                        FAB_RESET,
  input  logic                        RX_IN,
  output logic [7:0]                  DATA_OUT,
  output logic                        DATA_VALID,
  input  logic                        DATA_READY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        FRAME_ERR,
  output logic                        OVERRUN,
  output logic                        PARITY_ERR
);
  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic rx_s1, rx_s2, rx_prev, fall;
  rx_state_t state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [3:0] smp_cnt;
  logic [2:0] bit_cnt;
  logic s7, s8, perr, bit_val;
  logic [DATA_BITS-1:0] shreg;
  logic tick, samp_7, samp_8, samp_dec, samp_last;
  logic push_req, frame_err, parity_err, fifo_full, fifo_empty;

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX_IN;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall      = rx_prev & ~rx_s2;
  assign tick      = (state != IDLE) && (div_cnt == DW'(BAUD_DIV - 1));
  assign samp_7    = tick && (smp_cnt == 4'(SAMPLE_MID - 1));
  assign samp_8    = tick && (smp_cnt == 4'(SAMPLE_MID));
  assign samp_dec  = tick && (smp_cnt == 4'(SAMPLE_MID + 1));
  assign samp_last = tick && (smp_cnt == 4'(OVERSAMPLE - 1));
  assign bit_val   = maj3(s7, s8, rx_s2);

  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: begin
        if (samp_7 && rx_s2)  state_nxt = IDLE;
        else if (samp_last)   state_nxt = DATA;
      end
`ifdef UART_RX_PARITY_EN
      DATA:   if (samp_last && bit_cnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
      PARITY: if (samp_last) state_nxt = STOP;
`else
      DATA:   if (samp_last && bit_cnt == 3'(DATA_BITS - 1)) state_nxt = STOP;
`endif
      STOP:  if (samp_dec) state_nxt = bit_val ? IDLE : BREAK;
      BREAK: if (rx_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push_req   = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (!FAB_RESET && state == STOP && samp_dec) begin
      if (!bit_val)  frame_err = 1'b1;
      else if (!perr) push_req = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    if (!FAB_RESET && state == PARITY && samp_dec && (bit_val != ^shreg))
      parity_err = 1'b1;
`endif
  end

  // counters sit at zero in IDLE, which doubles as the reload on start detection
  always_ff @(posedge FAB_CCC_GL0) begin
    if (FAB_RESET) begin
      div_cnt <= '0;
      smp_cnt <= '0;
      bit_cnt <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      shreg   <= '0;
      perr    <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      smp_cnt <= '0;
      bit_cnt <= '0;
      perr    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)   smp_cnt <= smp_cnt + 1'b1;
      if (samp_7) s7 <= rx_s2;
      if (samp_8) s8 <= rx_s2;
      if (state == DATA && samp_dec)  shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
      if (state == DATA && samp_last) bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && samp_dec) perr <= (bit_val != ^shreg);
`endif
    end
  end

  fabric_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk   (FAB_CCC_GL0),
    .rst   (FAB_RESET),
    .push  (push_req),
    .pop   (DATA_READY),
    .din   (shreg),
    .dout  (DATA_OUT),
    .count (FIFO_COUNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign DATA_VALID = ~fifo_empty;
  assign FRAME_ERR  = frame_err;
  assign OVERRUN    = push_req & fifo_full & ~DATA_READY;
  assign PARITY_ERR = parity_err;
endmodule

// File: tb/tb_fabric_uart_rx.sv
// Directed bench for fabric_uart_rx with BAUD_DIV=4 (64 cycles per bit).
`timescale 1ns/1ps
module tb_fabric_uart_rx;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;

  logic       clk = 1'b0;
  logic       FAB_RESET = 1'b1;
  logic       RX_IN = 1'b1;
  logic       DATA_READY = 1'b0;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID, FRAME_ERR, OVERRUN, PARITY_ERR;
  logic [3:0] FIFO_COUNT;

  int tests = 0, fails = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vld_cyc = 0;
  logic [7:0] rx_q[$];

  fabric_uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(8)) dut (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET   (FAB_RESET),
    .RX_IN       (RX_IN),
    .DATA_OUT    (DATA_OUT),
    .DATA_VALID  (DATA_VALID),
    .DATA_READY  (DATA_READY),
    .FIFO_COUNT  (FIFO_COUNT),
    .FRAME_ERR   (FRAME_ERR),
    .OVERRUN     (OVERRUN),
    .PARITY_ERR  (PARITY_ERR)
  );

  always #5 clk = ~clk;

  // inputs change 2ns after posedge, so negedge sees what the next posedge will use
  always @(negedge clk) begin
    if (FRAME_ERR)  fe_cnt++;
    if (OVERRUN)    ov_cnt++;
    if (PARITY_ERR) pe_cnt++;
    if (DATA_VALID) vld_cyc++;
    if (DATA_VALID && DATA_READY) rx_q.push_back(DATA_OUT);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_b, input logic par_b);
    RX_IN = 1'b0; cyc(BIT);
    for (int i = 0; i < 8; i++) begin RX_IN = b[i]; cyc(BIT); end
`ifdef UART_RX_PARITY_EN
    RX_IN = par_b; cyc(BIT);
`endif
    RX_IN = stop_b; cyc(BIT);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset;
    FAB_RESET = 1'b1; RX_IN = 1'b1; DATA_READY = 1'b0;
    cyc(5);
    FAB_RESET = 1'b0;
    cyc(2);
    @(negedge clk);
    tests++; if (DATA_OUT !== 8'h00)  begin fails++; $display("FAIL reset_data_out got %0h exp 0", DATA_OUT); end
    tests++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", DATA_VALID); end
    tests++; if (FIFO_COUNT !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", FIFO_COUNT); end
    tests++; if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
      fails++; $display("FAIL reset_errs got %b exp 000", {FRAME_ERR, OVERRUN, PARITY_ERR}); end
  endtask

  task automatic test_basic;
    int q0, v0, f0, o0;
    DATA_READY = 1'b1;
    cyc(1);
    q0 = rx_q.size(); v0 = vld_cyc; f0 = fe_cnt; o0 = ov_cnt;
    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b1);
    cyc(20);
    tests++; if (rx_q.size() - q0 !== 2) begin fails++; $display("FAIL basic_count got %0d exp 2", rx_q.size() - q0); end
    else begin
      tests++; if (rx_q[q0] !== 8'hA5)   begin fails++; $display("FAIL basic_byte0 got %0h exp a5", rx_q[q0]); end
      tests++; if (rx_q[q0+1] !== 8'h3C) begin fails++; $display("FAIL basic_byte1 got %0h exp 3c", rx_q[q0+1]); end
    end
    tests++; if (vld_cyc - v0 !== 2) begin fails++; $display("FAIL basic_valid_cycles got %0d exp 2", vld_cyc - v0); end
    tests++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
      fails++; $display("FAIL basic_errs got fe=%0d ov=%0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
  endtask

  task automatic test_overrun;
    int q0, o0;
    logic [7:0] b;
    DATA_READY = 1'b0;
    cyc(1);
    q0 = rx_q.size(); o0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin b = 8'(i); send(b, 1'b1, ^b); end
    cyc(5);
    @(negedge clk);
    tests++; if (FIFO_COUNT !== 4'd8) begin fails++; $display("FAIL ovr_count8 got %0d exp 8", FIFO_COUNT); end
    tests++; if (ov_cnt - o0 !== 0)   begin fails++; $display("FAIL ovr_early got %0d exp 0", ov_cnt - o0); end
    tests++; if (DATA_VALID !== 1'b1 || DATA_OUT !== 8'h00) begin
      fails++; $display("FAIL ovr_head got v=%0b d=%0h exp 1 00", DATA_VALID, DATA_OUT); end
    send(8'h08, 1'b1, 1'b1);
    cyc(5);
    @(negedge clk);
    tests++; if (ov_cnt - o0 !== 1)   begin fails++; $display("FAIL ovr_pulse got %0d exp 1", ov_cnt - o0); end
    tests++; if (FIFO_COUNT !== 4'd8) begin fails++; $display("FAIL ovr_count_after got %0d exp 8", FIFO_COUNT); end
    cyc(1);
    DATA_READY = 1'b1;
    cyc(12);
    tests++; if (rx_q.size() - q0 !== 8) begin fails++; $display("FAIL ovr_drain_n got %0d exp 8", rx_q.size() - q0); end
    else for (int i = 0; i < 8; i++) begin
      tests++; if (rx_q[q0+i] !== 8'(i)) begin fails++; $display("FAIL ovr_drain%0d got %0h exp %0h", i, rx_q[q0+i], i); end
    end
    @(negedge clk);
    tests++; if (FIFO_COUNT !== 4'd0 || DATA_VALID !== 1'b0) begin
      fails++; $display("FAIL ovr_empty got c=%0d v=%0b exp 0 0", FIFO_COUNT, DATA_VALID); end
  endtask

  task automatic test_framing;
    int q0, f0;
    DATA_READY = 1'b1;
    cyc(1);
    q0 = rx_q.size(); f0 = fe_cnt;
    send(8'h55, 1'b0, 1'b0);
    RX_IN = 1'b0; cyc(200);
    RX_IN = 1'b1; cyc(BIT);
    send(8'h81, 1'b1, 1'b0);
    cyc(20);
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL frame_err_count got %0d exp 1", fe_cnt - f0); end
    tests++; if (rx_q.size() - q0 !== 1) begin fails++; $display("FAIL frame_rx_n got %0d exp 1", rx_q.size() - q0); end
    else begin
      tests++; if (rx_q[q0] !== 8'h81) begin fails++; $display("FAIL frame_rx_byte got %0h exp 81", rx_q[q0]); end
    end
  endtask

  task automatic test_glitch;
    int q0, f0;
    DATA_READY = 1'b1;
    cyc(1);
    q0 = rx_q.size(); f0 = fe_cnt;
    RX_IN = 1'b0; cyc(20);
    RX_IN = 1'b1; cyc(100);
    tests++; if (rx_q.size() - q0 !== 0 || fe_cnt - f0 !== 0) begin
      fails++; $display("FAIL glitch_quiet got rx=%0d fe=%0d exp 0 0", rx_q.size() - q0, fe_cnt - f0); end
    send(8'h5A, 1'b1, 1'b0);
    cyc(20);
    tests++; if (rx_q.size() - q0 !== 1) begin fails++; $display("FAIL glitch_next_n got %0d exp 1", rx_q.size() - q0); end
    else begin
      tests++; if (rx_q[q0] !== 8'h5A) begin fails++; $display("FAIL glitch_next_byte got %0h exp 5a", rx_q[q0]); end
    end
  endtask

  task automatic test_reset_midframe;
    int q0, f0;
    logic [7:0] b;
    DATA_READY = 1'b0;
    cyc(1);
    f0 = fe_cnt;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    cyc(5);
    @(negedge clk);
    tests++; if (FIFO_COUNT !== 4'd3) begin fails++; $display("FAIL rstmid_queued got %0d exp 3", FIFO_COUNT); end
    cyc(1);
    b = 8'hF0;
    RX_IN = 1'b0; cyc(BIT);
    for (int i = 0; i < 4; i++) begin RX_IN = b[i]; cyc(BIT); end
    RX_IN = b[4]; cyc(32);
    FAB_RESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (DATA_OUT !== 8'h00 || DATA_VALID !== 1'b0 || FIFO_COUNT !== 4'd0) begin
      fails++; $display("FAIL rstmid_outs got d=%0h v=%0b c=%0d exp 0 0 0", DATA_OUT, DATA_VALID, FIFO_COUNT); end
    tests++; if ({FRAME_ERR, OVERRUN, PARITY_ERR} !== 3'b000) begin
      fails++; $display("FAIL rstmid_errs got %b exp 000", {FRAME_ERR, OVERRUN, PARITY_ERR}); end
    cyc(1);
    FAB_RESET = 1'b0; RX_IN = 1'b1;
    cyc(BIT);
    DATA_READY = 1'b1;
    q0 = rx_q.size();
    send(8'h12, 1'b1, 1'b0);
    cyc(20);
    tests++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL rstmid_no_fe got %0d exp 0", fe_cnt - f0); end
    tests++; if (rx_q.size() - q0 !== 1) begin fails++; $display("FAIL rstmid_next_n got %0d exp 1", rx_q.size() - q0); end
    else begin
      tests++; if (rx_q[q0] !== 8'h12) begin fails++; $display("FAIL rstmid_next_byte got %0h exp 12", rx_q[q0]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int q0, p0;
    DATA_READY = 1'b1;
    cyc(1);
    q0 = rx_q.size(); p0 = pe_cnt;
    send(8'h07, 1'b1, 1'b0);
    cyc(20);
    tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL par_bad_pulse got %0d exp 1", pe_cnt - p0); end
    tests++; if (rx_q.size() - q0 !== 0) begin fails++; $display("FAIL par_bad_drop got %0d exp 0", rx_q.size() - q0); end
    send(8'h07, 1'b1, 1'b1);
    cyc(20);
    tests++; if (pe_cnt - p0 !== 1) begin fails++; $display("FAIL par_good_pulse got %0d exp 1", pe_cnt - p0); end
    tests++; if (rx_q.size() - q0 !== 1) begin fails++; $display("FAIL par_good_n got %0d exp 1", rx_q.size() - q0); end
    else begin
      tests++; if (rx_q[q0] !== 8'h07) begin fails++; $display("FAIL par_good_byte got %0h exp 07", rx_q[q0]); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_overrun;
    test_framing;
    test_glitch;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    tests++; if (pe_cnt !== 0 && 0) fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
